// File: rtl/root_pkg.sv
// root_pkg: shared definitions for the root-extraction dispatcher.
//   Q10.10 result widths, exponent/tag widths, dispatcher FSM state
//   encoding, the queued request record and a helper that lifts an
//   integer into Q10.10.
package root_pkg;
    localparam int INT_W  = 10;
    localparam int FRAC_W = 10;
    localparam int RES_W  = INT_W + FRAC_W;
    localparam int EXP_W  = 3;
    localparam int TAG_W  = 4;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_e;

    typedef struct packed {
        logic [INT_W-1:0] base;
        logic [EXP_W-1:0] exp;
        logic [TAG_W-1:0] tag;
    } req_t;

    function automatic logic [RES_W-1:0] to_q(input logic [INT_W-1:0] b);
        return {b, {FRAC_W{1'b0}}};
    endfunction
endpackage

// File: rtl/root_req_fifo.sv
// root_req_fifo: synchronous request FIFO for the root dispatcher.
//   clk, rst_n  : rising-edge clock, synchronous active-low reset
//   push_i      : write wdata_i (ignored when full)
//   pop_i       : advance head (ignored when empty)
//   wdata_i     : request record to enqueue
//   rdata_o     : head-of-queue record
//   count_o     : occupancy, clog2(DEPTH)+1 bits
//   full_o      : count_o == DEPTH
//   empty_o     : count_o == 0
module root_req_fifo
    import root_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  req_t                   wdata_i,
    output req_t                   rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    req_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;
    logic            do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/root_dispatch.sv
// root_dispatch: queues root requests and feeds them one at a time to an
// external root engine, returning tagged Q10.10 results in request order.
//   clk, rst_n                      : rising-edge clock, sync active-low reset
//   req_valid/req_ready             : request handshake
//   req_base/req_exp/req_tag        : radicand, root order, caller ID
//   eng_in_valid                    : one-cycle engine start pulse
//   eng_data_1/eng_data_2           : engine operands (base, exp), held per job
//   eng_out_valid/eng_out_data      : engine completion and Q10.10 result
//   res_valid/res_ready             : result handshake
//   res_data/res_tag                : Q10.10 result and its caller ID
// Build option: ROOT_DISPATCH_BYPASS_EN -- jobs with exp==1 are answered
// directly as {base,0} without starting the engine.
module root_dispatch
    import root_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [INT_W-1:0] req_base,
    input  logic [EXP_W-1:0] req_exp,
    input  logic [TAG_W-1:0] req_tag,
    output logic             eng_in_valid,
    output logic [INT_W-1:0] eng_data_1,
    output logic [EXP_W-1:0] eng_data_2,
    input  logic             eng_out_valid,
    input  logic [RES_W-1:0] eng_out_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data,
    output logic [TAG_W-1:0] res_tag
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e           state_q, state_d;
    req_t             job_q, job_d, head, req_in;
    logic             res_valid_q, res_valid_d;
    logic [RES_W-1:0] res_data_q, res_data_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [CW-1:0]    fifo_cnt;
    logic             fifo_full, fifo_empty, push, pop;

    // Readiness comes from the registered count only, so a pop in the same
    // cycle never opens room for a push into a full queue.
    assign req_ready = fifo_cnt < CW'(DEPTH);
    assign push      = req_valid && !fifo_full;
    assign req_in    = {req_base, req_exp, req_tag};

    root_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (req_in),
        .rdata_o (head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign eng_in_valid = state_q == S_ISSUE;
    assign eng_data_1   = job_q.base;
    assign eng_data_2   = job_q.exp;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_tag      = res_tag_q;

    // A job is only popped while the result slot is empty, so the slot can
    // never be overwritten while it still holds an unconsumed result.
    always_comb begin
        state_d     = state_q;
        job_d       = job_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;
        pop         = 1'b0;
        if (res_valid_q && res_ready) res_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !res_valid_q) begin
                    pop     = 1'b1;
                    job_d   = head;
                    state_d = S_ISSUE;
`ifdef ROOT_DISPATCH_BYPASS_EN
                    if (head.exp == EXP_W'(1)) begin
                        res_valid_d = 1'b1;
                        res_data_d  = to_q(head.base);
                        res_tag_d   = head.tag;
                        state_d     = S_HOLD;
                    end
`endif
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (eng_out_valid) begin
                    res_valid_d = 1'b1;
                    res_data_d  = eng_out_data;
                    res_tag_d   = job_q.tag;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            job_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            job_q       <= job_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
        end
    end
endmodule

// File: tb/tb_root_dispatch.sv
// tb_root_dispatch: directed self-checking bench for root_dispatch with a
// behavioural root engine (fixed latency, exact integer roots).
module tb_root_dispatch;
    localparam int DEPTH = 4;
`ifdef ROOT_DISPATCH_BYPASS_EN
    localparam int EXP1_STARTS = 0;
`else
    localparam int EXP1_STARTS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        res_ready = 1'b1;
    logic [9:0]  req_base = '0;
    logic [2:0]  req_exp = '0;
    logic [3:0]  req_tag = '0;
    logic        req_ready, eng_in_valid, res_valid, eng_out_valid;
    logic [9:0]  eng_data_1;
    logic [2:0]  eng_data_2;
    logic [19:0] eng_out_data, res_data;
    logic [3:0]  res_tag;
    logic        auto_ov = 1'b0, man_ov = 1'b0;
    logic [19:0] auto_data = '0, man_data = '0;
    int checks = 0, failures = 0;
    int starts = 0, stab_err = 0, cyc = 0, last_start = 0, prev_start = 0;

    always #5 clk = ~clk;

    assign eng_out_valid = auto_ov | man_ov;
    assign eng_out_data  = man_ov ? man_data : auto_data;

    root_dispatch #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_base      (req_base),
        .req_exp       (req_exp),
        .req_tag       (req_tag),
        .eng_in_valid  (eng_in_valid),
        .eng_data_1    (eng_data_1),
        .eng_data_2    (eng_data_2),
        .eng_out_valid (eng_out_valid),
        .eng_out_data  (eng_out_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_tag       (res_tag)
    );

    function automatic logic [19:0] root_q(input logic [9:0] b, input logic [2:0] e);
        longint p;
        for (int r = 0; r < 1024; r++) begin
            p = 1;
            for (int k = 0; k < int'(e); k++) p = p * r;
            if (p == longint'(b)) return 20'(r) << 10;
            if (p > longint'(b)) break;
        end
        return '0;
    endfunction

    // Engine: latches operands on eng_in_valid, answers 4 cycles later,
    // and flags any operand change while it is computing.
    logic [9:0] e_base;
    logic [2:0] e_exp;
    int         e_cnt;
    logic       e_busy = 1'b0;
    always begin
        logic       rs, iv;
        logic [9:0] d1;
        logic [2:0] d2;
        @(posedge clk);
        rs = rst_n;
        iv = eng_in_valid;
        d1 = eng_data_1;
        d2 = eng_data_2;
        #1;
        cyc++;
        auto_ov = 1'b0;
        if (!rs) e_busy = 1'b0;
        else if (e_busy) begin
            if (d2 !== e_exp || d1 !== e_base) stab_err++;
            if (e_cnt == 0) begin
                auto_ov   = 1'b1;
                auto_data = root_q(e_base, e_exp);
                e_busy    = 1'b0;
            end else e_cnt--;
        end else if (iv) begin
            e_busy     = 1'b1;
            e_base     = d1;
            e_exp      = d2;
            e_cnt      = 2;
            starts++;
            prev_start = last_start;
            last_start = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [9:0] b, input logic [2:0] e, input logic [3:0] t);
        req_valid = 1'b1;
        req_base  = b;
        req_exp   = e;
        req_tag   = t;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_res(output bit ok);
        for (int i = 0; i < 50 && !res_valid; i++) tick();
        ok = res_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++;
        if (eng_in_valid !== 1'b0) begin failures++; $display("FAIL reset_eng_in_valid got=%b exp=0", eng_in_valid); end
        checks++;
        if ({eng_data_1, eng_data_2} !== 13'd0) begin failures++; $display("FAIL reset_eng_data got=%h exp=0", {eng_data_1, eng_data_2}); end
        checks++;
        if ({res_data, res_tag} !== 24'd0) begin failures++; $display("FAIL reset_res got=%h exp=0", {res_data, res_tag}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n;
        push(10'd4, 3'd2, 4'd3);
        checks++;
        if (eng_in_valid !== 1'b0) begin failures++; $display("FAIL single_early_issue got=%b exp=0", eng_in_valid); end
        tick();
        checks++;
        if (eng_in_valid !== 1'b1) begin failures++; $display("FAIL single_issue_latency got=%b exp=1", eng_in_valid); end
        n = 0;
        while (!res_valid && n < 50) begin tick(); n++; end
        checks++;
        if (n != 5) begin failures++; $display("FAIL single_res_latency got=%0d exp=5", n); end
        checks++;
        if (res_data !== 20'h00800 || res_tag !== 4'd3) begin failures++; $display("FAIL single_result got=%h/%h exp=00800/3", res_data, res_tag); end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL single_res_clear got=%b exp=0", res_valid); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int s0 = starts;
        push(10'd27, 3'd3, 4'd1);
        push(10'd16, 3'd4, 4'd2);
        wait_res(ok);
        checks++;
        if (!ok || res_data !== 20'h00C00 || res_tag !== 4'd1) begin failures++; $display("FAIL b2b_first got=%b/%h/%h exp=1/00c00/1", ok, res_data, res_tag); end
        tick();
        wait_res(ok);
        checks++;
        if (!ok || res_data !== 20'h00800 || res_tag !== 4'd2) begin failures++; $display("FAIL b2b_second got=%b/%h/%h exp=1/00800/2", ok, res_data, res_tag); end
        checks++;
        if (starts - s0 != 2) begin failures++; $display("FAIL b2b_starts got=%0d exp=2", starts - s0); end
        checks++;
        if (last_start - prev_start != 7) begin failures++; $display("FAIL b2b_issue_spacing got=%0d exp=7", last_start - prev_start); end
        checks++;
        if (stab_err != 0) begin failures++; $display("FAIL b2b_operand_stable got=%0d exp=0", stab_err); end
        tick();
    endtask

    task automatic test_backpressure();
        int acc = 0, got = 0;
        int s0 = starts;
        bit a;
        res_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (acc < DEPTH + 2) begin
                req_valid = 1'b1;
                req_base  = 10'((acc + 1) * (acc + 1));
                req_exp   = 3'd2;
                req_tag   = 4'(acc + 1);
            end else req_valid = 1'b0;
            a = req_valid && req_ready;
            tick();
            if (a) acc++;
        end
        checks++;
        if (acc != DEPTH + 1) begin failures++; $display("FAIL bp_accepted got=%0d exp=%0d", acc, DEPTH + 1); end
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_req_ready got=%b exp=0", req_ready); end
        checks++;
        if (res_valid !== 1'b1 || res_tag !== 4'd1 || res_data !== 20'h00400) begin failures++; $display("FAIL bp_held got=%b/%h/%h exp=1/1/00400", res_valid, res_tag, res_data); end
        checks++;
        if (starts - s0 != 1) begin failures++; $display("FAIL bp_starts got=%0d exp=1", starts - s0); end
        res_ready = 1'b1;
        for (int c = 0; c < 200 && got < DEPTH + 2; c++) begin
            if (acc < DEPTH + 2) begin
                req_valid = 1'b1;
                req_base  = 10'((acc + 1) * (acc + 1));
                req_exp   = 3'd2;
                req_tag   = 4'(acc + 1);
            end else req_valid = 1'b0;
            a = req_valid && req_ready;
            if (res_valid) begin
                checks++;
                if (res_tag !== 4'(got + 1) || res_data !== 20'((got + 1) << 10)) begin
                    failures++;
                    $display("FAIL bp_order_%0d got=%h/%h exp=%h/%h", got, res_tag, res_data, 4'(got + 1), 20'((got + 1) << 10));
                end
                got++;
            end
            tick();
            if (a) acc++;
        end
        req_valid = 1'b0;
        checks++;
        if (got != DEPTH + 2 || acc != DEPTH + 2) begin failures++; $display("FAIL bp_drain got=%0d/%0d exp=%0d", got, acc, DEPTH + 2); end
        tick();
    endtask

    task automatic test_reset_mid();
        int s0, bad = 0;
        res_ready = 1'b1;
        push(10'd1, 3'd2, 4'd1);
        push(10'd4, 3'd2, 4'd2);
        push(10'd9, 3'd2, 4'd3);
        push(10'd16, 3'd2, 4'd4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1 || eng_in_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs got=%b%b%b exp=010", res_valid, req_ready, eng_in_valid);
        end
        checks++;
        if (eng_data_1 !== 10'd0) begin failures++; $display("FAIL midrst_eng_data got=%h exp=0", eng_data_1); end
        s0 = starts;
        man_data = 20'hABCDE;
        man_ov = 1'b1;
        tick();
        man_ov = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b0 || eng_in_valid !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || starts != s0) begin failures++; $display("FAIL midrst_late_ov got=%0d/%0d exp=0/0", bad, starts - s0); end
    endtask

    task automatic test_exp1();
        bit ok;
        int s0 = starts;
        push(10'd5, 3'd1, 4'd7);
        wait_res(ok);
        checks++;
        if (!ok || res_data !== 20'h01400 || res_tag !== 4'd7) begin failures++; $display("FAIL exp1_result got=%b/%h/%h exp=1/01400/7", ok, res_data, res_tag); end
        checks++;
        if (starts - s0 != EXP1_STARTS) begin failures++; $display("FAIL exp1_engine_starts got=%0d exp=%0d", starts - s0, EXP1_STARTS); end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_exp1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
